// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder: qualifies a trigger, waits the burst delay, then drives a registered echo
// pulse of distance_cm*US_PER_CM ticks (TIMEOUT_US if out of range); no backpressure, tick-paced.
module sr04_echo_emulator #(
  parameter int unsigned MIN_TRIG_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 200,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1us,
  input  logic       trigger,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       short_trig,
  output logic       echo_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_DELAY,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0] MIN_TRIG   = 16'(MIN_TRIG_US);
  localparam logic [15:0] DELAY_LAST = 16'(ECHO_DELAY_US - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_US);
  localparam logic [15:0] CM_FACTOR  = 16'(US_PER_CM);
  localparam logic [15:0] MAX_DIST   = 16'(MAX_CM);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [15:0] width_q, width_d;
  logic [15:0] dist_ext, dist_width;
  logic        out_of_range;
  logic        echo_q, echo_d;
  logic        short_q, short_d;
  logic        done_q, done_d;

  // Saturating so a trigger held forever parks at 0xFFFF instead of wrapping.
  assign cnt_inc      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign dist_ext     = {7'd0, distance_cm};
  assign out_of_range = (dist_ext == 16'd0) || (dist_ext > MAX_DIST);
  assign dist_width   = out_of_range ? TIMEOUT_W : dist_ext * CM_FACTOR;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick_1us ? cnt_inc : cnt_q;
    width_d = width_q;
    echo_d  = echo_q;
    short_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (trigger) begin
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (!trigger) begin
          cnt_d = '0;
          if (cnt_q >= MIN_TRIG) begin
            width_d = dist_width;
            state_d = S_DELAY;
          end else begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DELAY: begin
        if (tick_1us && (cnt_q == DELAY_LAST)) begin
          cnt_d   = '0;
          echo_d  = 1'b1;
          state_d = S_ECHO;
        end
      end
      S_ECHO: begin
        if (tick_1us && (cnt_q == width_q - 16'd1)) begin
          cnt_d   = '0;
          echo_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (tick_1us && (cnt_q == HOLD_LAST)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        echo_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      short_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      short_q <= short_d;
      done_q  <= done_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = (state_q != S_IDLE);
  assign short_trig = short_q;
  assign echo_done  = done_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Bench for sr04_echo_emulator: randomized trigger/distance/tick stimulus checked against
// an arithmetic reference of echo delay, width and holdoff measured in tick_1us strobes.
module tb_sr04_echo_emulator;

  localparam int MIN_TRIG = 10;
  localparam int DLY      = 200;
  localparam int UPC      = 58;
  localparam int MAXC     = 400;
  localparam int TMO      = 2000;
  localparam int HOLD     = 150;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1us = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distance_cm = 9'd0;
  logic       echo, busy, short_trig, echo_done;

  sr04_echo_emulator #(
    .MIN_TRIG_US  (MIN_TRIG),
    .ECHO_DELAY_US(DLY),
    .US_PER_CM    (UPC),
    .MAX_CM       (MAXC),
    .TIMEOUT_US   (TMO),
    .HOLDOFF_US   (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1us   (tick_1us),
    .trigger    (trigger),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig),
    .echo_done  (echo_done)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_chk = 0;
  bit         gap_mode = 1'b0;
  logic       trig_v = 1'b0;
  logic       rst_v = 1'b1;
  logic [8:0] dist_v = 9'd0;
  int         done_cnt = 0;
  int         short_cnt = 0;
  int         both_cnt = 0;

  int t, dly, wid, hold;
  bit df, tmo;

  // Reference: echo width in microsecond ticks for a given latched distance.
  function automatic int exp_width(input int d);
    if (d == 0 || d > MAXC) return TMO;
    return d * UPC;
  endfunction

  // One clock cycle: inputs applied just after the edge, outputs observed at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1us    = gap_mode ? ($urandom_range(0, 1) == 0) : 1'b1;
    trigger     = trig_v;
    reset       = rst_v;
    distance_cm = dist_v;
    @(negedge clk);
    if (echo_done === 1'b1) done_cnt++;
    if (short_trig === 1'b1) short_cnt++;
    if (echo_done === 1'b1 && short_trig === 1'b1) both_cnt++;
  endtask

  // Trigger high for n cycles; returns ticks seen after the first high cycle.
  task automatic pulse(input int n, output int ticks);
    ticks  = 0;
    trig_v = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i > 0 && tick_1us) ticks++;
    end
    trig_v = 1'b0;
  endtask

  // Follows one measurement from the trigger-fall cycle until busy drops.
  task automatic measure(input int new_dist, input int ew, output int o_dly, output int o_wid,
                         output int o_hold, output bit o_df, output bit o_tmo);
    int g;
    o_dly = 0; o_wid = 0; o_hold = 0; o_df = 1'b0; o_tmo = 1'b0;
    cyc();
    if (new_dist >= 0) dist_v = 9'(new_dist);
    g = 0;
    forever begin
      cyc(); g++;
      if (echo === 1'b1) break;
      if (tick_1us) o_dly++;
      if (g > 3 * DLY + 20) begin o_tmo = 1'b1; return; end
    end
    if (tick_1us) o_wid++;
    g = 0;
    forever begin
      cyc(); g++;
      if (echo !== 1'b1) break;
      if (tick_1us) o_wid++;
      if (g > 3 * ew + 50) begin o_tmo = 1'b1; return; end
    end
    o_df = (echo_done === 1'b1);
    if (tick_1us) o_hold++;
    g = 0;
    forever begin
      cyc(); g++;
      if (busy !== 1'b1) break;
      if (tick_1us) o_hold++;
      if (g > 3 * HOLD + 50) begin o_tmo = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst_v = 1'b1; trig_v = 1'b1; dist_v = 9'd100;
    repeat (3) cyc();
    trig_v = 1'b0; rst_v = 1'b0;
    cyc();
    n_chk++; if (echo !== 1'b0) $display("FAIL reset_echo: got %b expected 0", echo); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_chk++; if (short_trig !== 1'b0) $display("FAIL reset_short: got %b expected 0", short_trig); else n_pass++;
    n_chk++; if (echo_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", echo_done); else n_pass++;
    cyc();
    done_cnt = 0; short_cnt = 0;
  endtask

  task automatic test_distance_100();
    int d0;
    dist_v = 9'd100; d0 = done_cnt;
    pulse(11, t);
    measure(-1, exp_width(100), dly, wid, hold, df, tmo);
    n_chk++; if (tmo) $display("FAIL d100_timeout: measurement did not complete"); else n_pass++;
    n_chk++; if (dly !== DLY) $display("FAIL d100_delay: got %0d ticks expected %0d", dly, DLY); else n_pass++;
    n_chk++; if (wid !== exp_width(100)) $display("FAIL d100_width: got %0d ticks expected %0d", wid, exp_width(100)); else n_pass++;
    n_chk++; if (df !== 1'b1) $display("FAIL d100_done_at_fall: got %b expected 1", df); else n_pass++;
    n_chk++; if (hold !== HOLD) $display("FAIL d100_holdoff: got %0d ticks expected %0d", hold, HOLD); else n_pass++;
    n_chk++; if (done_cnt - d0 !== 1) $display("FAIL d100_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_out_of_range();
    int dl[2];
    dl[0] = 0; dl[1] = 401;
    foreach (dl[i]) begin
      dist_v = 9'(dl[i]);
      pulse(11, t);
      measure(-1, exp_width(dl[i]), dly, wid, hold, df, tmo);
      n_chk++; if (tmo) $display("FAIL oor_timeout: dist %0d did not complete", dl[i]); else n_pass++;
      n_chk++; if (wid !== exp_width(dl[i])) $display("FAIL oor_width: dist %0d got %0d expected %0d", dl[i], wid, exp_width(dl[i])); else n_pass++;
      n_chk++; if (df !== 1'b1) $display("FAIL oor_done: dist %0d got %b expected 1", dl[i], df); else n_pass++;
    end
  endtask

  task automatic test_short_trig();
    int nl[2];
    int s0, d;
    nl[0] = 5; nl[1] = 10;
    foreach (nl[i]) begin
      s0 = short_cnt;
      pulse(nl[i], t);
      cyc();
      cyc();
      n_chk++; if (short_trig !== (t < MIN_TRIG)) $display("FAIL short_pulse: len %0d got %b expected %b", nl[i], short_trig, t < MIN_TRIG); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL short_busy: len %0d got %b expected 0", nl[i], busy); else n_pass++;
      repeat (5) cyc();
      n_chk++; if (echo !== 1'b0 || short_cnt - s0 !== 1) $display("FAIL short_once: echo %b pulses %0d expected echo 0 pulses 1", echo, short_cnt - s0); else n_pass++;
    end
    d = $urandom_range(1, 20);
    dist_v = 9'(d);
    pulse(12, t);
    measure(-1, exp_width(d), dly, wid, hold, df, tmo);
    n_chk++; if (tmo || wid !== exp_width(d)) $display("FAIL after_short_width: tmo %b got %0d expected %0d", tmo, wid, exp_width(d)); else n_pass++;
    n_chk++; if (dly !== DLY) $display("FAIL after_short_delay: got %0d expected %0d", dly, DLY); else n_pass++;
  endtask

  task automatic test_latch();
    dist_v = 9'd400;
    pulse(11, t);
    measure(10, exp_width(400), dly, wid, hold, df, tmo);
    n_chk++; if (tmo) $display("FAIL latch_timeout: measurement did not complete"); else n_pass++;
    n_chk++; if (wid !== exp_width(400)) $display("FAIL latch_width: got %0d expected %0d", wid, exp_width(400)); else n_pass++;
    n_chk++; if (df !== 1'b1) $display("FAIL latch_done: got %b expected 1", df); else n_pass++;
  endtask

  task automatic test_ignored();
    int d, d0, s0;
    d = $urandom_range(1, 20);
    dist_v = 9'(d); d0 = done_cnt; s0 = short_cnt;
    pulse(11, t);
    fork
      measure(-1, exp_width(d), dly, wid, hold, df, tmo);
      begin
        int k;
        k = 0;
        while (echo !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        trig_v = 1'b1;
        repeat (15) @(negedge clk);
        trig_v = 1'b0;
        k = 0;
        while (echo !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        trig_v = 1'b1;
        repeat (15) @(negedge clk);
        trig_v = 1'b0;
        repeat (75) @(negedge clk);
        trig_v = 1'b1;
      end
    join
    n_chk++; if (tmo || wid !== exp_width(d)) $display("FAIL ignore_width: tmo %b got %0d expected %0d", tmo, wid, exp_width(d)); else n_pass++;
    n_chk++; if (hold !== HOLD) $display("FAIL ignore_holdoff: got %0d expected %0d", hold, HOLD); else n_pass++;
    n_chk++; if (done_cnt - d0 !== 1 || short_cnt - s0 !== 0) $display("FAIL ignore_pulses: done %0d short %0d expected 1 and 0", done_cnt - d0, short_cnt - s0); else n_pass++;
    repeat (20) cyc();
    trig_v = 1'b0;
    d = $urandom_range(1, 20);
    dist_v = 9'(d);
    measure(-1, exp_width(d), dly, wid, hold, df, tmo);
    n_chk++; if (tmo || wid !== exp_width(d)) $display("FAIL retrigger_width: tmo %b got %0d expected %0d", tmo, wid, exp_width(d)); else n_pass++;
    n_chk++; if (dly !== DLY) $display("FAIL retrigger_delay: got %0d expected %0d", dly, DLY); else n_pass++;
  endtask

  task automatic test_reset_mid_echo();
    int k, d0, d;
    dist_v = 9'd50;
    pulse(11, t);
    cyc();
    k = 0;
    while (echo !== 1'b1 && k < 1000) begin cyc(); k++; end
    n_chk++; if (echo !== 1'b1) $display("FAIL rst_echo_rise: got %b expected 1", echo); else n_pass++;
    repeat (100) cyc();
    d0 = done_cnt;
    rst_v = 1'b1;
    cyc();
    rst_v = 1'b0;
    cyc();
    n_chk++; if (echo !== 1'b0) $display("FAIL rst_mid_echo: got %b expected 0", echo); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
    n_chk++; if (echo_done !== 1'b0 || short_trig !== 1'b0) $display("FAIL rst_mid_pulses: done %b short %b expected 0 0", echo_done, short_trig); else n_pass++;
    repeat (5) cyc();
    n_chk++; if (done_cnt !== d0) $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt - d0); else n_pass++;
    d = $urandom_range(1, 20);
    dist_v = 9'(d);
    pulse(11, t);
    measure(-1, exp_width(d), dly, wid, hold, df, tmo);
    n_chk++; if (tmo || wid !== exp_width(d)) $display("FAIL rst_after_width: tmo %b got %0d expected %0d", tmo, wid, exp_width(d)); else n_pass++;
  endtask

  task automatic test_random();
    int r, d, n, s0, d0;
    gap_mode = 1'b1;
    for (int it = 0; it < 4; it++) begin
      r = $urandom_range(0, 5);
      if (r == 0) d = 0;
      else if (r == 1) d = $urandom_range(401, 511);
      else d = $urandom_range(1, 20);
      n = $urandom_range(8, 40);
      dist_v = 9'(d); s0 = short_cnt; d0 = done_cnt;
      pulse(n, t);
      if (t >= MIN_TRIG) begin
        measure($urandom_range(0, 511), exp_width(d), dly, wid, hold, df, tmo);
        n_chk++; if (tmo || dly !== DLY) $display("FAIL rand_delay: it %0d tmo %b got %0d expected %0d", it, tmo, dly, DLY); else n_pass++;
        n_chk++; if (wid !== exp_width(d)) $display("FAIL rand_width: it %0d dist %0d got %0d expected %0d", it, d, wid, exp_width(d)); else n_pass++;
        n_chk++; if (hold !== HOLD || done_cnt - d0 !== 1) $display("FAIL rand_holdoff: it %0d hold %0d done %0d expected %0d and 1", it, hold, done_cnt - d0, HOLD); else n_pass++;
      end else begin
        cyc();
        cyc();
        n_chk++; if (short_trig !== 1'b1 || busy !== 1'b0) $display("FAIL rand_short: it %0d short %b busy %b expected 1 0", it, short_trig, busy); else n_pass++;
        repeat (5) cyc();
        n_chk++; if (echo !== 1'b0 || short_cnt - s0 !== 1) $display("FAIL rand_short_once: it %0d echo %b pulses %0d expected 0 1", it, echo, short_cnt - s0); else n_pass++;
      end
    end
    gap_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_distance_100();
    test_out_of_range();
    test_short_trig();
    test_latch();
    test_ignored();
    test_reset_mid_echo();
    test_random();
    n_chk++; if (both_cnt !== 0) $display("FAIL pulse_overlap: got %0d cycles expected 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
